// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game datapath: sign-magnitude trig
// values, screen coordinates and the bullet slot state encoding.
package tank_pkg;

    typedef struct packed {
        logic       neg;
        logic [6:0] mag;
    } trig_t;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_e;

    localparam coord_t SCREEN_MAX_X = 10'd639;
    localparam coord_t SCREEN_MAX_Y = 10'd479;

endpackage

// File: rtl/bullet_slot.sv
// One bullet: IDLE/ACTIVE state, age and bounce counters, velocity and position.
// Kill priority each frame is hit, then lifetime, then the final allowed bounce.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int LIFETIME    = 1000,
    parameter int MAX_BOUNCES = 0
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               spawn,
    input  logic [9:0]         spawn_x,
    input  logic [9:0]         spawn_y,
    input  logic signed [9:0]  spawn_vx,
    input  logic signed [9:0]  spawn_vy,
    input  logic               wall_x,
    input  logic               wall_y,
    input  logic               hit,
    output logic               active,
    output logic [9:0]         pos_x,
    output logic [9:0]         pos_y
);

    localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(LIFETIME - 1);
    localparam logic [8:0] BOUNCE_LIMIT = 9'(MAX_BOUNCES);

    slot_state_e        state_q, state_d;
    coord_t             pos_x_q, pos_y_q;
    logic signed [9:0]  vx_q, vy_q;
    logic signed [9:0]  vx_refl, vy_refl;
    logic [AGE_W-1:0]   age_q;
    logic [7:0]         bounce_q;
    logic [8:0]         bounce_nxt;
    logic               refl, age_kill, bounce_kill, move;

    function automatic logic [7:0] sat_inc(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        refl        = wall_x | wall_y;
        vx_refl     = wall_x ? -vx_q : vx_q;
        vy_refl     = wall_y ? -vy_q : vy_q;
        bounce_nxt  = {1'b0, bounce_q} + 9'd1;
        age_kill    = (age_q == AGE_LAST);
        bounce_kill = (MAX_BOUNCES != 0) && refl && (bounce_nxt >= BOUNCE_LIMIT);
        state_d     = state_q;
        move        = 1'b0;
        case (state_q)
            IDLE:   if (spawn) state_d = ACTIVE;
            ACTIVE: begin
                if (hit || age_kill || bounce_kill) state_d = IDLE;
                else                                move    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active = (state_q == ACTIVE);
        pos_x  = pos_x_q;
        pos_y  = pos_y_q;
    end

    // Reflection is applied before the move so a wall frame already heads away.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            age_q    <= '0;
            bounce_q <= '0;
        end else if (state_q == IDLE && spawn) begin
            pos_x_q  <= spawn_x;
            pos_y_q  <= spawn_y;
            vx_q     <= spawn_vx;
            vy_q     <= spawn_vy;
            age_q    <= '0;
            bounce_q <= '0;
        end else if (move) begin
            vx_q    <= vx_refl;
            vy_q    <= vy_refl;
            pos_x_q <= pos_x_q + coord_t'(vx_refl);
            pos_y_q <= pos_y_q + coord_t'(vy_refl);
            age_q   <= age_q + AGE_W'(1);
            if (refl) bounce_q <= sat_inc(bounce_nxt);
        end
    end

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fire edge detection with cooldown, lowest-free-slot allocation,
// spawn velocity/position from the tank heading, and a live-slot count.
module bullet_pool
    import tank_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int LIFETIME    = 1000,
    parameter int COOLDOWN    = 8,
    parameter int STEP        = 16,
    parameter int SPAWN_MULT  = 5,
    parameter int MAX_BOUNCES = 0
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      fire,
    input  logic [9:0]                tankX,
    input  logic [9:0]                tankY,
    input  logic [7:0]                sin,
    input  logic [7:0]                cos,
    input  logic [NUM_BULLETS-1:0]    wall_bottom,
    input  logic [NUM_BULLETS-1:0]    wall_top,
    input  logic [NUM_BULLETS-1:0]    wall_right,
    input  logic [NUM_BULLETS-1:0]    wall_left,
    input  logic [NUM_BULLETS-1:0]    hit,
    output logic [NUM_BULLETS-1:0]    active,
    output logic [10*NUM_BULLETS-1:0] bullet_x,
    output logic [10*NUM_BULLETS-1:0] bullet_y,
    output logic [3:0]                active_count,
    output logic                      fire_dropped
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [6:0] STEP_W = 7'(STEP);
    localparam logic signed [9:0] SPAWN_K = 10'(SPAWN_MULT);

    logic                    fire_p1;
    logic [CD_W-1:0]         cd_q;
    logic                    fire_edge, accept, found, drop;
    logic [NUM_BULLETS-1:0]  spawn_sel, spawn_vec;
    logic signed [9:0]       vx, vy, off_x, off_y;
    coord_t                  spawn_x, spawn_y;

    // Magnitude is truncated (floor), so STEP*127 lands one short of STEP.
    function automatic logic signed [9:0] trig_to_vel(input trig_t t, input logic flip);
        logic [13:0]       prod;
        logic signed [9:0] v;
        prod = {7'd0, STEP_W} * {7'd0, t.mag};
        v    = signed'({3'b000, prod[13:7]});
        return (t.neg ^ flip) ? -v : v;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_BULLETS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_BULLETS; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    always_comb begin
        fire_edge = fire & ~fire_p1;
        accept    = fire_edge && (cd_q == '0);
        spawn_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!found && !active[i]) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
        spawn_vec = accept ? spawn_sel : '0;
        drop      = accept && !found;
    end

    // Screen y grows downward, so a positive sine moves the bullet up.
    always_comb begin
        vx      = trig_to_vel(trig_t'(cos), 1'b0);
        vy      = trig_to_vel(trig_t'(sin), 1'b1);
        off_x   = SPAWN_K * vx;
        off_y   = SPAWN_K * vy;
        spawn_x = tankX + coord_t'(off_x);
        spawn_y = tankY + coord_t'(off_y);
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            fire_p1      <= 1'b0;
            cd_q         <= '0;
            fire_dropped <= 1'b0;
            active_count <= '0;
        end else begin
            fire_p1      <= fire;
            fire_dropped <= drop;
            active_count <= popcount(active);
            if (accept)            cd_q <= CD_LOAD;
            else if (cd_q != '0)   cd_q <= cd_q - CD_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .LIFETIME    (LIFETIME),
            .MAX_BOUNCES (MAX_BOUNCES)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .spawn     (spawn_vec[g]),
            .spawn_x   (spawn_x),
            .spawn_y   (spawn_y),
            .spawn_vx  (vx),
            .spawn_vy  (vy),
            .wall_x    (wall_left[g] | wall_right[g]),
            .wall_y    (wall_top[g] | wall_bottom[g]),
            .hit       (hit[g]),
            .active    (active[g]),
            .pos_x     (bullet_x[10*g +: 10]),
            .pos_y     (bullet_y[10*g +: 10])
        );
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: a default instance and a short-lived,
// two-bounce instance share the stimulus; each test resets before use.
module tb_bullet_pool;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic        fire;
    logic [9:0]  tankX, tankY;
    logic [7:0]  sin, cos;
    logic [3:0]  wall_bottom, wall_top, wall_right, wall_left, hit;
    logic [3:0]  active, s_active;
    logic [39:0] bullet_x, bullet_y, s_bullet_x, s_bullet_y;
    logic [3:0]  active_count, s_active_count;
    logic        fire_dropped, s_fire_dropped;

    int checks   = 0;
    int failures = 0;

    always #5 frame_clk = ~frame_clk;

    bullet_pool u_dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .fire         (fire),
        .tankX        (tankX),
        .tankY        (tankY),
        .sin          (sin),
        .cos          (cos),
        .wall_bottom  (wall_bottom),
        .wall_top     (wall_top),
        .wall_right   (wall_right),
        .wall_left    (wall_left),
        .hit          (hit),
        .active       (active),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .active_count (active_count),
        .fire_dropped (fire_dropped)
    );

    bullet_pool #(.LIFETIME(10), .MAX_BOUNCES(2)) u_short (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .fire         (fire),
        .tankX        (tankX),
        .tankY        (tankY),
        .sin          (sin),
        .cos          (cos),
        .wall_bottom  (wall_bottom),
        .wall_top     (wall_top),
        .wall_right   (wall_right),
        .wall_left    (wall_left),
        .hit          (hit),
        .active       (s_active),
        .bullet_x     (s_bullet_x),
        .bullet_y     (s_bullet_y),
        .active_count (s_active_count),
        .fire_dropped (s_fire_dropped)
    );

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        fire    = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        tick();
        fire = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        fire    = 1'b1;
        tick();
        tick();
        checks++; if (active !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", active); end
        checks++; if (active_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", active_count); end
        checks++; if (fire_dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", fire_dropped); end
        checks++; if (bullet_x !== 40'd0 || bullet_y !== 40'd0) begin failures++; $display("FAIL reset_pos got x=%h y=%h exp 0", bullet_x, bullet_y); end
        fire    = 1'b0;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_spawn();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        fire_pulse();
        checks++; if (active !== 4'b0001) begin failures++; $display("FAIL spawn_active got=%b exp=0001", active); end
        checks++; if (bullet_x[9:0] !== 10'd175 || bullet_y[9:0] !== 10'd200) begin failures++; $display("FAIL spawn_pos got=%0d,%0d exp=175,200", bullet_x[9:0], bullet_y[9:0]); end
        tick();
        checks++; if (bullet_x[9:0] !== 10'd190 || bullet_y[9:0] !== 10'd200) begin failures++; $display("FAIL first_move got=%0d,%0d exp=190,200", bullet_x[9:0], bullet_y[9:0]); end
        checks++; if (active_count !== 4'd1) begin failures++; $display("FAIL count_one got=%0d exp=1", active_count); end
    endtask

    task automatic test_negative_wrap();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'hC0; sin = 8'hC0;
        fire_pulse();
        checks++; if (bullet_x[9:0] !== 10'd60 || bullet_y[9:0] !== 10'd240) begin failures++; $display("FAIL neg_spawn got=%0d,%0d exp=60,240", bullet_x[9:0], bullet_y[9:0]); end
        tick();
        checks++; if (bullet_x[9:0] !== 10'd52 || bullet_y[9:0] !== 10'd248) begin failures++; $display("FAIL neg_move got=%0d,%0d exp=52,248", bullet_x[9:0], bullet_y[9:0]); end
        repeat (9) tick();
        tankX = 10'd10; tankY = 10'd1020;
        fire_pulse();
        checks++; if (bullet_x[19:10] !== 10'd994 || bullet_y[19:10] !== 10'd36) begin failures++; $display("FAIL wrap_spawn got=%0d,%0d exp=994,36", bullet_x[19:10], bullet_y[19:10]); end
    endtask

    task automatic test_cooldown();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        fire = 1'b1;
        repeat (20) tick();
        fire = 1'b0;
        checks++; if (active !== 4'b0001) begin failures++; $display("FAIL held_fire got=%b exp=0001", active); end
        do_reset();
        fire_pulse();
        tick();
        tick();
        fire_pulse();
        checks++; if (active !== 4'b0001) begin failures++; $display("FAIL cooldown_ignore got=%b exp=0001", active); end
        repeat (6) tick();
        fire_pulse();
        checks++; if (active !== 4'b0011) begin failures++; $display("FAIL cooldown_refire got=%b exp=0011", active); end
        checks++; if (bullet_x[19:10] !== 10'd175) begin failures++; $display("FAIL refire_pos got=%0d exp=175", bullet_x[19:10]); end
    endtask

    task automatic test_pool_full();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        for (int k = 0; k < 4; k++) begin
            fire_pulse();
            repeat (9) tick();
        end
        checks++; if (active !== 4'b1111 || active_count !== 4'd4) begin failures++; $display("FAIL full_before got=%b/%0d exp=1111/4", active, active_count); end
        fire_pulse();
        checks++; if (fire_dropped !== 1'b1) begin failures++; $display("FAIL dropped_pulse got=%b exp=1", fire_dropped); end
        checks++; if (active !== 4'b1111) begin failures++; $display("FAIL full_active got=%b exp=1111", active); end
        tick();
        checks++; if (fire_dropped !== 1'b0) begin failures++; $display("FAIL dropped_clear got=%b exp=0", fire_dropped); end
        checks++; if (active_count !== 4'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", active_count); end
    endtask

    task automatic test_corner();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h7F;
        fire_pulse();
        checks++; if (bullet_x[9:0] !== 10'd175 || bullet_y[9:0] !== 10'd125) begin failures++; $display("FAIL corner_spawn got=%0d,%0d exp=175,125", bullet_x[9:0], bullet_y[9:0]); end
        wall_right = 4'b0001; wall_top = 4'b0001;
        tick();
        wall_right = 4'b0000; wall_top = 4'b0000;
        checks++; if (bullet_x[9:0] !== 10'd160 || bullet_y[9:0] !== 10'd140) begin failures++; $display("FAIL corner_reflect got=%0d,%0d exp=160,140", bullet_x[9:0], bullet_y[9:0]); end
        tick();
        checks++; if (bullet_x[9:0] !== 10'd145 || bullet_y[9:0] !== 10'd155) begin failures++; $display("FAIL corner_after got=%0d,%0d exp=145,155", bullet_x[9:0], bullet_y[9:0]); end
    endtask

    task automatic test_lifetime();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        fire_pulse();
        repeat (9) tick();
        checks++; if (s_active[0] !== 1'b1 || s_bullet_x[9:0] !== 10'd310) begin failures++; $display("FAIL life_9 got=%b,%0d exp=1,310", s_active[0], s_bullet_x[9:0]); end
        tick();
        checks++; if (s_active[0] !== 1'b0) begin failures++; $display("FAIL life_10 got=%b exp=0", s_active[0]); end
        tick();
        checks++; if (s_bullet_x[9:0] !== 10'd310) begin failures++; $display("FAIL idle_hold got=%0d exp=310", s_bullet_x[9:0]); end
    endtask

    task automatic test_bounce();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        fire_pulse();
        tick();
        wall_right = 4'b0001;
        tick();
        wall_right = 4'b0000;
        checks++; if (s_active[0] !== 1'b1 || s_bullet_x[9:0] !== 10'd175) begin failures++; $display("FAIL bounce_1 got=%b,%0d exp=1,175", s_active[0], s_bullet_x[9:0]); end
        tick();
        wall_left = 4'b0001;
        tick();
        wall_left = 4'b0000;
        checks++; if (s_active[0] !== 1'b0 || s_bullet_x[9:0] !== 10'd160) begin failures++; $display("FAIL bounce_2 got=%b,%0d exp=0,160", s_active[0], s_bullet_x[9:0]); end
    endtask

    task automatic test_hit_and_reset();
        do_reset();
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        fire_pulse();
        repeat (9) tick();
        fire_pulse();
        repeat (9) tick();
        hit  = 4'b1010;
        fire = 1'b1;
        tick();
        hit  = 4'b0000;
        fire = 1'b0;
        checks++; if (active !== 4'b0101) begin failures++; $display("FAIL hit_spawn got=%b exp=0101", active); end
        checks++; if (bullet_x[29:20] !== 10'd175) begin failures++; $display("FAIL slot2_pos got=%0d exp=175", bullet_x[29:20]); end
        tick();
        Reset_n = 1'b0;
        fire    = 1'b1;
        tick();
        checks++; if (active !== 4'b0000 || bullet_x !== 40'd0) begin failures++; $display("FAIL mid_reset got=%b x=%h exp=0000 x=0", active, bullet_x); end
        fire    = 1'b0;
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; fire = 1'b0;
        tankX = 10'd100; tankY = 10'd200; cos = 8'h7F; sin = 8'h00;
        wall_bottom = '0; wall_top = '0; wall_right = '0; wall_left = '0; hit = '0;
        #1;
        test_reset();
        test_spawn();
        test_negative_wrap();
        test_cooldown();
        test_pool_full();
        test_corner();
        test_lifetime();
        test_bounce();
        test_hit_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
